// File: rtl/rbt_s_ipv6_parser.sv
// rtl/rbt_s_ipv6_parser.sv - IPv6 fixed-header parser stage with registered output and 1-entry skid
// Extracts IPv6 fields into the PHV, strips the 40-byte header and counts malformed beats.
module rbt_s_ipv6_parser #(
    parameter int HEADER_WIDTH = 2048,
    parameter int PHV_WIDTH    = 408,
    parameter int PHV_B_NUM    = 7,
    parameter int PHV_H_NUM    = 2,
    parameter int PHV_W_NUM    = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_proto_hdr_valid,
    output logic                    in_proto_hdr_ready,
    input  logic [15:0]             in_proto_hdr_length,
    input  logic [HEADER_WIDTH-1:0] in_proto_hdr_data,
    input  logic [PHV_WIDTH-1:0]    in_proto_hdr_phv,
    output logic                    out_proto_hdr_valid,
    input  logic                    out_proto_hdr_ready,
    output logic [HEADER_WIDTH-1:0] out_proto_hdr_data,
    output logic [15:0]             out_proto_hdr_length,
    output logic [PHV_WIDTH-1:0]    out_proto_hdr_phv,
    output logic [15:0]             err_cnt
);

    localparam int H_BASE = 8 * PHV_B_NUM;
    localparam int W_BASE = H_BASE + 16 * PHV_H_NUM;
    localparam int HW     = HEADER_WIDTH;

    logic [HW-1:0]        p_data;
    logic [15:0]          p_len;
    logic [PHV_WIDTH-1:0] p_phv;
    logic                 p_err;
    logic [7:0]           nh;

    always_comb begin
        p_data = in_proto_hdr_data;
        p_len  = in_proto_hdr_length;
        p_phv  = in_proto_hdr_phv;
        p_err  = 1'b0;
        nh     = in_proto_hdr_data[HW-1-48 -: 8];
        if (in_proto_hdr_phv[W_BASE+4]) begin
            if (in_proto_hdr_data[HW-1 -: 4] != 4'h6 || in_proto_hdr_length < 16'd40) begin
                p_phv[W_BASE+4] = 1'b0;
                p_err           = 1'b1;
            end else begin
                p_phv[H_BASE +: 16] = in_proto_hdr_data[HW-1-32 -: 16];
                p_phv[0 +: 8]       = nh;
                p_phv[8 +: 8]       = in_proto_hdr_data[HW-1-56 -: 8];
                p_phv[40 +: 8]      = in_proto_hdr_phv[32 +: 8] + 8'd40;
                // src address lands in W[2..5], dst in W[6..9]: contiguous bytes 8..39
                for (int k = 0; k < 8; k++) begin
                    p_phv[W_BASE+64+32*k +: 32] = in_proto_hdr_data[HW-1-64-32*k -: 32];
                end
                if (nh == 8'd6)  p_phv[W_BASE+5] = 1'b1;
                if (nh == 8'd17) p_phv[W_BASE+6] = 1'b1;
                p_data = in_proto_hdr_data << 320;
                p_len  = in_proto_hdr_length - 16'd40;
            end
        end
    end

    logic                 out_valid_q, out_valid_d;
    logic [HW-1:0]        out_data_q, out_data_d;
    logic [15:0]          out_len_q, out_len_d;
    logic [PHV_WIDTH-1:0] out_phv_q, out_phv_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [HW-1:0]        skid_data_q, skid_data_d;
    logic [15:0]          skid_len_q, skid_len_d;
    logic [PHV_WIDTH-1:0] skid_phv_q, skid_phv_d;
    logic                 in_rdy_q, in_rdy_d;
    logic [15:0]          err_q, err_d;
    logic                 out_free, in_fire;

    // rst gating keeps a stale registered handshake from looking like a transfer
    assign in_proto_hdr_ready   = in_rdy_q & ~rst;
    assign out_proto_hdr_valid  = out_valid_q & ~rst;
    assign out_proto_hdr_data   = out_data_q;
    assign out_proto_hdr_length = out_len_q;
    assign out_proto_hdr_phv    = out_phv_q;
    assign err_cnt              = err_q;

    assign out_free = ~out_valid_q | out_proto_hdr_ready;
    assign in_fire  = in_proto_hdr_valid & in_proto_hdr_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_len_d    = out_len_q;
        out_phv_d    = out_phv_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_len_d   = skid_len_q;
        skid_phv_d   = skid_phv_q;
        // in ready is low whenever the skid is full, so no new beat competes with a drain
        if (skid_valid_q) begin
            if (out_free) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_len_d    = skid_len_q;
                out_phv_d    = skid_phv_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (out_free) begin
                out_valid_d = 1'b1;
                out_data_d  = p_data;
                out_len_d   = p_len;
                out_phv_d   = p_phv;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = p_data;
                skid_len_d   = p_len;
                skid_phv_d   = p_phv;
            end
        end else if (out_free) begin
            out_valid_d = 1'b0;
        end
        in_rdy_d = ~skid_valid_d;
        err_d    = (in_fire && p_err && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_len_q    <= '0;
            out_phv_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_len_q   <= '0;
            skid_phv_q   <= '0;
            in_rdy_q     <= 1'b1;
            err_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_len_q    <= out_len_d;
            out_phv_q    <= out_phv_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_len_q   <= skid_len_d;
            skid_phv_q   <= skid_phv_d;
            in_rdy_q     <= in_rdy_d;
            err_q        <= err_d;
        end
    end

endmodule
